// File: rtl/rom_fetch_if.sv
// Bundles the core-side handshake and the ROM read bus of the sequential fetch unit.
interface rom_fetch_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          JMP_I;
  logic [AW-1:0] JMP_ADDR_I;
  logic          POP_I;
  logic          VLD_O;
  logic [DW-1:0] DAT_O;
  logic [AW-1:0] PC_O;
  logic          CS_O;
  logic          RD_O;
  logic [AW-1:0] ADDR_O;
  logic [DW-1:0] DAT_I;

  modport master (
    input  JMP_I, JMP_ADDR_I, POP_I, DAT_I,
    output VLD_O, DAT_O, PC_O, CS_O, RD_O, ADDR_O
  );

  modport slave (
    output JMP_I, JMP_ADDR_I, POP_I, DAT_I,
    input  VLD_O, DAT_O, PC_O, CS_O, RD_O, ADDR_O
  );
endinterface

// File: rtl/rom_fetch.sv
// Sequential program-ROM read initiator with a small prefetch FIFO and jump/flush.
// One access in flight at a time; a new access only starts while the FIFO has room.
module rom_fetch #(
  parameter int AW    = 13,
  parameter int DW    = 8,
  parameter int WAIT  = 0,
  parameter int DEPTH = 4
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  rom_fetch_if.master  bus
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WCW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [WCW-1:0] WAIT_C  = WCW'(WAIT);

  typedef enum logic {IDLE, ACC} state_t;

  state_t         state, state_nxt;
  logic           cs, cs_nxt;
  logic [AW-1:0]  addr, addr_nxt;
  logic [AW-1:0]  fa, fa_nxt;
  logic [AW-1:0]  pc, pc_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic [CW-1:0]  count, count_nxt;
  logic [PW-1:0]  wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]  rd_ptr, rd_ptr_nxt;
  logic [DW-1:0]  mem [DEPTH];

  logic vld;
  logic pop;
  logic capture;

  assign vld     = (count != '0);
  // A jump wins over both a pop and a capture on the same edge.
  assign pop     = bus.POP_I & vld & ~bus.JMP_I;
  assign capture = (state == ACC) && (wcnt == '0) && !bus.JMP_I;

  always_comb begin
    state_nxt  = state;
    cs_nxt     = cs;
    addr_nxt   = addr;
    wcnt_nxt   = wcnt;
    count_nxt  = count + CW'(capture) - CW'(pop);
    wr_ptr_nxt = capture ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt = pop     ? rd_ptr + PW'(1) : rd_ptr;
    fa_nxt     = capture ? fa + AW'(1)     : fa;
    pc_nxt     = pop     ? pc + AW'(1)     : pc;

    case (state)
      IDLE: begin
        if (count < DEPTH_C) begin
          state_nxt = ACC;
          cs_nxt    = 1'b1;
          addr_nxt  = fa;
          wcnt_nxt  = WAIT_C;
        end
      end
      ACC: begin
        if (wcnt != '0) begin
          wcnt_nxt = wcnt - WCW'(1);
        end else if (count_nxt < DEPTH_C) begin
          addr_nxt = fa + AW'(1);
          wcnt_nxt = WAIT_C;
        end else begin
          state_nxt = IDLE;
          cs_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cs_nxt    = 1'b0;
      end
    endcase

    // Flush drops the FIFO and any in-flight byte, and re-aims fetch and PC.
    if (bus.JMP_I) begin
      state_nxt  = IDLE;
      cs_nxt     = 1'b0;
      wcnt_nxt   = '0;
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      fa_nxt     = bus.JMP_ADDR_I;
      pc_nxt     = bus.JMP_ADDR_I;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state  <= IDLE;
      cs     <= 1'b0;
      addr   <= '0;
      fa     <= '0;
      pc     <= '0;
      wcnt   <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      cs     <= cs_nxt;
      addr   <= addr_nxt;
      fa     <= fa_nxt;
      pc     <= pc_nxt;
      wcnt   <= wcnt_nxt;
      count  <= count_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Storage is data only; emptiness is tracked by count, so no reset is needed here.
  always_ff @(posedge CLK_I) begin
    if (capture) begin
      mem[wr_ptr] <= bus.DAT_I;
    end
  end

  assign bus.CS_O   = cs;
  assign bus.RD_O   = cs;
  assign bus.ADDR_O = addr;
  assign bus.PC_O   = pc;
  assign bus.VLD_O  = vld;
  assign bus.DAT_O  = vld ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_rom_fetch.sv
// Directed bench for rom_fetch: one instance with WAIT=0 and one with WAIT=2, each with its own ROM image.
module tb_rom_fetch;

  logic clk;
  logic rst0;
  logic rst2;
  int   tests;
  int   fails;

  logic [7:0] rom0 [8192];
  logic [7:0] rom2 [8192];

  rom_fetch_if #(.AW(13), .DW(8)) b0 ();
  rom_fetch_if #(.AW(13), .DW(8)) b2 ();

  rom_fetch #(.AW(13), .DW(8), .WAIT(0), .DEPTH(4)) u0 (
    .CLK_I (clk),
    .RST_I (rst0),
    .bus   (b0)
  );

  rom_fetch #(.AW(13), .DW(8), .WAIT(2), .DEPTH(4)) u2 (
    .CLK_I (clk),
    .RST_I (rst2),
    .bus   (b2)
  );

  assign b0.DAT_I = rom0[b0.ADDR_O];
  assign b2.DAT_I = rom2[b2.ADDR_O];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] stream_exp [8];

  initial begin
    tests = 0;
    fails = 0;
    stream_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8192; i++) begin
      rom0[i] = ~8'(i);
      rom2[i] = ~8'(i);
    end
    for (int i = 0; i < 8; i++) rom0[i] = stream_exp[i];
    rom0[13'h1FFE] = 8'h01;
    rom0[13'h1FFF] = 8'h02;
    rom2[0]        = 8'hA5;
    rom2[1]        = 8'hB6;
    rom2[2]        = 8'hEE;
    rom2[13'h0100] = 8'hC3;

    rst0 = 1'b1;
    rst2 = 1'b1;
    b0.JMP_I = 1'b0; b0.JMP_ADDR_I = '0; b0.POP_I = 1'b0;
    b2.JMP_I = 1'b0; b2.JMP_ADDR_I = '0; b2.POP_I = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst0_cs",   32'(b0.CS_O),   32'h0);
    chk("rst0_rd",   32'(b0.RD_O),   32'h0);
    chk("rst0_addr", 32'(b0.ADDR_O), 32'h0);
    chk("rst0_vld",  32'(b0.VLD_O),  32'h0);
    chk("rst0_dat",  32'(b0.DAT_O),  32'h0);
    chk("rst0_pc",   32'(b0.PC_O),   32'h0);
    chk("rst2_cs",   32'(b2.CS_O),   32'h0);
    chk("rst2_vld",  32'(b2.VLD_O),  32'h0);

    // Fill: four back-to-back accesses, then stop with the FIFO full.
    rst0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_cs",   32'(b0.CS_O),   32'h1);
      chk("fill_addr", 32'(b0.ADDR_O), 32'(i));
    end
    tick();
    chk("full_cs",  32'(b0.CS_O),  32'h0);
    chk("full_vld", 32'(b0.VLD_O), 32'h1);
    chk("full_dat", 32'(b0.DAT_O), 32'h11);
    chk("full_pc",  32'(b0.PC_O),  32'h0);
    repeat (2) begin
      tick();
      chk("full_idle_cs", 32'(b0.CS_O), 32'h0);
    end

    // Stream: pop every cycle.
    b0.POP_I = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("stream_dat", 32'(b0.DAT_O), 32'(stream_exp[i]));
      chk("stream_pc",  32'(b0.PC_O),  32'(i));
      if (i >= 2) chk("stream_cs", 32'(b0.CS_O), 32'h1);
      tick();
    end
    b0.POP_I = 1'b0;

    // Wrap across the top of the address space.
    rom0[0] = 8'h03;
    b0.JMP_I = 1'b1;
    b0.JMP_ADDR_I = 13'h1FFE;
    tick();
    b0.JMP_I = 1'b0;
    chk("jmpw_cs",  32'(b0.CS_O),  32'h0);
    chk("jmpw_vld", 32'(b0.VLD_O), 32'h0);
    chk("jmpw_dat", 32'(b0.DAT_O), 32'h0);
    chk("jmpw_pc",  32'(b0.PC_O),  32'h1FFE);
    tick();
    chk("wrap_cs",    32'(b0.CS_O),   32'h1);
    chk("wrap_addr0", 32'(b0.ADDR_O), 32'h1FFE);
    tick();
    chk("wrap_addr1", 32'(b0.ADDR_O), 32'h1FFF);
    chk("wrap_dat0",  32'(b0.DAT_O),  32'h01);
    chk("wrap_pc0",   32'(b0.PC_O),   32'h1FFE);
    tick();
    chk("wrap_addr2", 32'(b0.ADDR_O), 32'h0000);
    b0.POP_I = 1'b1;
    tick();
    chk("wrap_dat1", 32'(b0.DAT_O), 32'h02);
    chk("wrap_pc1",  32'(b0.PC_O),  32'h1FFF);
    tick();
    chk("wrap_dat2", 32'(b0.DAT_O), 32'h03);
    chk("wrap_pc2",  32'(b0.PC_O),  32'h0000);
    b0.POP_I = 1'b0;

    // Held jump keeps the unit flushed.
    b0.JMP_I = 1'b1;
    b0.JMP_ADDR_I = 13'h0010;
    repeat (3) begin
      tick();
      chk("jhold_cs",  32'(b0.CS_O),  32'h0);
      chk("jhold_vld", 32'(b0.VLD_O), 32'h0);
      chk("jhold_pc",  32'(b0.PC_O),  32'h0010);
    end
    b0.JMP_I = 1'b0;
    tick();
    chk("j10_cs",   32'(b0.CS_O),   32'h1);
    chk("j10_addr", 32'(b0.ADDR_O), 32'h0010);
    tick();
    chk("j10_vld", 32'(b0.VLD_O), 32'h1);
    chk("j10_dat", 32'(b0.DAT_O), 32'hEF);
    chk("j10_cs2", 32'(b0.CS_O),  32'h1);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #2;
    rst0 = 1'b1;
    #1;
    chk("arst_cs",   32'(b0.CS_O),   32'h0);
    chk("arst_rd",   32'(b0.RD_O),   32'h0);
    chk("arst_vld",  32'(b0.VLD_O),  32'h0);
    chk("arst_dat",  32'(b0.DAT_O),  32'h0);
    chk("arst_pc",   32'(b0.PC_O),   32'h0);
    chk("arst_addr", 32'(b0.ADDR_O), 32'h0);
    @(negedge clk);
    rst0 = 1'b0;
    tick();
    chk("arst_re_cs",   32'(b0.CS_O),   32'h1);
    chk("arst_re_addr", 32'(b0.ADDR_O), 32'h0);
    tick();
    chk("arst_re_vld", 32'(b0.VLD_O), 32'h1);
    chk("arst_re_dat", 32'(b0.DAT_O), 32'h03);

    // Wait states on the WAIT=2 instance.
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_cs",   32'(b2.CS_O),   32'h1);
      chk("ws_rd",   32'(b2.RD_O),   32'h1);
      chk("ws_addr", 32'(b2.ADDR_O), 32'h0);
      chk("ws_vld",  32'(b2.VLD_O),  32'h0);
    end
    tick();
    chk("ws_vld1",  32'(b2.VLD_O),  32'h1);
    chk("ws_dat1",  32'(b2.DAT_O),  32'hA5);
    chk("ws_addr1", 32'(b2.ADDR_O), 32'h1);
    repeat (2) begin
      tick();
      chk("ws_hold_addr", 32'(b2.ADDR_O), 32'h1);
      chk("ws_hold_cs",   32'(b2.CS_O),   32'h1);
    end
    tick();
    chk("ws_addr2", 32'(b2.ADDR_O), 32'h2);
    chk("ws_dat_h", 32'(b2.DAT_O),  32'hA5);

    // Jump during the second cycle of the access to address 2.
    tick();
    b2.JMP_I = 1'b1;
    b2.JMP_ADDR_I = 13'h0100;
    tick();
    b2.JMP_I = 1'b0;
    chk("jm_cs",  32'(b2.CS_O),  32'h0);
    chk("jm_vld", 32'(b2.VLD_O), 32'h0);
    chk("jm_dat", 32'(b2.DAT_O), 32'h0);
    chk("jm_pc",  32'(b2.PC_O),  32'h0100);
    tick();
    chk("jm_acc_cs",   32'(b2.CS_O),   32'h1);
    chk("jm_acc_addr", 32'(b2.ADDR_O), 32'h0100);
    repeat (2) tick();
    chk("jm_pre_vld", 32'(b2.VLD_O), 32'h0);
    tick();
    chk("jm_vld1", 32'(b2.VLD_O), 32'h1);
    chk("jm_dat1", 32'(b2.DAT_O), 32'hC3);
    chk("jm_pc1",  32'(b2.PC_O),  32'h0100);
    b2.POP_I = 1'b1;
    tick();
    chk("pop_vld", 32'(b2.VLD_O), 32'h0);
    chk("pop_dat", 32'(b2.DAT_O), 32'h0);
    chk("pop_pc",  32'(b2.PC_O),  32'h0101);
    tick();
    chk("pop_empty_pc",  32'(b2.PC_O),  32'h0101);
    chk("pop_empty_vld", 32'(b2.VLD_O), 32'h0);
    b2.POP_I = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom_fetch.md
Name: rom_fetch

Overview:
Sequential read initiator for the 8 KB program ROM in the MCS8 design. Drives the ROM's chip-select, read strobe and 13-bit address, samples the returned byte and buffers it in a small prefetch FIFO. Presents the FIFO head to the CPU core through a valid/pop handshake, with a jump/flush input for control transfers.

Parameters:
AW, 13, address width; byte addresses wrap modulo 2^AW
DW, 8, data width
WAIT, 0, extra cycles each access holds CS_O/RD_O before sampling (access length = WAIT+1 cycles)
DEPTH, 4, prefetch FIFO depth in bytes (power of two, >=2)

Ports:
CLK_I  in  1  clock, all logic on rising edge
RST_I  in  1  asynchronous, active-high reset
JMP_I  in  1  flush FIFO, restart fetching at JMP_ADDR_I
JMP_ADDR_I  in  AW  jump target address
POP_I  in  1  core consumes head byte; effective only when VLD_O=1
VLD_O  out  1  FIFO non-empty
DAT_O  out  DW  FIFO head byte; forced to 0 when VLD_O=0
PC_O  out  AW  ROM address of head byte (next byte the core will receive)
CS_O  out  1  ROM chip select, registered
RD_O  out  1  ROM read strobe, registered, always equal to CS_O
ADDR_O  out  AW  ROM address, registered
DAT_I  in  DW  ROM data; combinational from ADDR_O, valid while CS_O&RD_O

Behaviour:
- Reset (async assert): CS_O=RD_O=0, ADDR_O=0, VLD_O=0, DAT_O=0, PC_O=0, fetch address FA=0, FIFO count=0, wait counter=0, state IDLE.
- States: IDLE (no access), ACC (access in progress).
- IDLE->ACC at edge when count<DEPTH and JMP_I=0: registers CS_O=RD_O=1, ADDR_O=FA, wait counter=WAIT.
- ACC, wait counter>0: hold CS/RD/ADDR, decrement counter.
- ACC, wait counter=0: at this edge DAT_I written to FIFO tail, FA<=FA+1 (mod 2^AW). If count after the edge (including any same-edge pop) <DEPTH: stay ACC with ADDR_O=FA+1, counter=WAIT (back-to-back; WAIT=0 gives one byte/cycle). Else go IDLE, CS_O=RD_O=0, ADDR_O holds.
- Only one access is in flight; starting only when count<DEPTH guarantees no write to a full FIFO.
- Captured byte appears at DAT_O with VLD_O=1 the cycle after its sampling edge (when FIFO was empty).
- Pop: when POP_I&VLD_O at edge, head removed, PC_O<=PC_O+1 (mod 2^AW). POP_I with VLD_O=0 ignored, no state change.
- Simultaneous capture and pop: count unchanged, both pointers advance.
- JMP_I at edge (priority over POP_I and capture): FIFO cleared (count=0), FA<=JMP_ADDR_I, PC_O<=JMP_ADDR_I, in-flight access aborted and its data discarded, state IDLE, CS_O=RD_O=0. Next edge starts access at JMP_ADDR_I if JMP_I low. VLD_O=0 in cycle after JMP. Repeated JMP_I holds block flushed.
- Wrap: FA and PC_O roll 2^AW-1 -> 0 with no gap.
- Reset mid-access: immediate return to reset values, partial data discarded.
- Invariant: PC_O + count == FA (mod 2^AW) whenever state IDLE or at access start.

Test Plan:
- Fill: ROM[0..3]=11,22,33,44, WAIT=0, POP_I=0 after reset -> ADDR_O 0,1,2,3 on four consecutive CS_O=1 cycles, then CS_O=0; VLD_O=1, DAT_O=11, PC_O=0, no further access.
- Stream: continue with POP_I=1 every cycle -> DAT_O sequence 11,22,33,44,ROM[4]...; PC_O increments each pop; CS_O stays high continuously, FIFO never overflows.
- Wait states: WAIT=2, ROM[0]=A5 -> CS_O/RD_O high with ADDR_O=0 for exactly 3 cycles, VLD_O=1 DAT_O=A5 the following cycle; next address 1 held 3 cycles.
- Jump mid-access: WAIT=2, pulse JMP_I with JMP_ADDR_I=0100 during second cycle of an access, ROM[0100]=C3 -> next cycle CS_O=0, VLD_O=0, PC_O=0100; following access at ADDR_O=0100; DAT_O=C3; discarded byte never appears.
- Wrap: jump to 1FFE, ROM[1FFE]=01, ROM[1FFF]=02, ROM[0]=03 -> ADDR_O 1FFE,1FFF,0000; popping yields 01,02,03 with PC_O 1FFE,1FFF,0000.
- Async reset during access: assert RST_I mid-cycle while CS_O=1 -> CS_O, RD_O, VLD_O, DAT_O, PC_O, ADDR_O go 0 without a clock edge; after release fetch restarts at 0.
